// File: rtl/sprite_cmd_pkg.sv
// Command-word layout, action codes, component IDs and sequencer states shared
// by the sprite command sequencer and the sprite display blocks.
package sprite_cmd_pkg;

   localparam int CMD_W       = 32;
   localparam int COMP_LSB    = 26;
   localparam int COMP_W      = 6;
   localparam int ACTION_LSB  = 17;
   localparam int ACTION_W    = 4;
   localparam int TYPE_LSB    = 14;
   localparam int TYPE_W      = 3;
   localparam int BUF_BIT     = 13;
   localparam int DATA_W      = 13;

   typedef struct packed {
      logic [5:0]  component;
      logic [4:0]  reserved;
      logic [3:0]  action;
      logic [2:0]  action_type;
      logic        buffer;
      logic [12:0] data;
   } sprite_cmd_t;

   localparam logic [3:0] ACTION_NOP   = 4'h0;
   localparam logic [3:0] ACTION_WRITE = 4'h1;
   localparam logic [3:0] ACTION_SWAP  = 4'hF;

   localparam logic [5:0] COMPONENT_ID_SPRITE_0 = 6'd0;
   localparam logic [5:0] COMPONENT_ID_SPRITE_1 = 6'd1;
   localparam logic [5:0] COMPONENT_ID_SPRITE_2 = 6'd2;
   localparam logic [5:0] COMPONENT_ID_SPRITE_3 = 6'd3;
   localparam logic [5:0] COMPONENT_ID_SPRITE_4 = 6'd4;
   localparam logic [5:0] COMPONENT_ID_SPRITE_5 = 6'd5;
   localparam logic [5:0] COMPONENT_ID_SPRITE_6 = 6'd6;
   localparam logic [5:0] COMPONENT_ID_SPRITE_7 = 6'd7;
   localparam logic [5:0] COMPONENT_ID_SPRITE_8 = 6'd8;
   localparam logic [5:0] COMPONENT_ID_SPRITE_9 = 6'd9;
   localparam logic [5:0] COMPONENT_ID_SPRITE_10 = 6'd10;

   typedef enum logic [0:0] {
      ST_DRAIN   = 1'b0,
      ST_WAIT_VB = 1'b1
   } seq_state_t;

   function automatic sprite_cmd_t make_swap_cmd(input logic back_buf);
      sprite_cmd_t c;
      c        = sprite_cmd_t'(32'h0000_0000);
      c.action = ACTION_SWAP;
      c.buffer = back_buf;
      return c;
   endfunction

   // The host's buffer bit is never trusted: every write lands in the back buffer.
   function automatic sprite_cmd_t to_back_buffer(input sprite_cmd_t c, input logic back_buf);
      sprite_cmd_t r;
      r        = c;
      r.buffer = back_buf;
      return r;
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with combinational head, full/empty/count status and
// simultaneous push/pop at any occupancy (including full).
module cmd_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 32,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign full      = (count_r == CW'(DEPTH));
   assign empty     = (count_r == {CW{1'b0}});
   assign count     = count_r;
   assign head      = mem_r[rd_ptr_r];
   assign pop_ok_s  = pop && !empty;
   assign push_ok_s = push && (!full || pop_ok_s);

   // Storage array; contents need no reset since count gates visibility.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
         if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/sprite_cmd_sequencer.sv
// Buffers host sprite commands, broadcasts them into the back buffer one per
// cycle, and converts commits into a single vblank-aligned buffer swap per frame.
// Optional status readback port is enabled by defining SEQ_STATUS_EN.
module sprite_cmd_sequencer #(
   parameter int FIFO_DEPTH = 16,
   parameter int V_ACTIVE   = 480,
   parameter int V_TOTAL    = 525
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        avs_write,
   input  logic        avs_chipselect,
   input  logic [31:0] avs_writedata,
   output logic        avs_waitrequest,
   input  logic [9:0]  vcount,
   output logic [31:0] writedata,
   output logic        front_buffer
`ifdef SEQ_STATUS_EN
   ,
   input  logic        avs_read,
   output logic [31:0] avs_readdata
`endif
);

   import sprite_cmd_pkg::*;

   localparam int         CNT_W          = $clog2(FIFO_DEPTH) + 1;
   localparam logic [9:0] V_FIRST_BLANK  = 10'(V_ACTIVE);
   localparam logic [9:0] V_LAST_BLANK   = 10'(V_TOTAL - 2);

   seq_state_t        state_r;
   seq_state_t        state_nxt_s;
   logic [31:0]       writedata_r;
   logic [31:0]       wd_nxt_s;
   logic              front_r;
   logic              swap_armed_r;
   logic              swap_s;
   logic              pop_s;
   logic              push_s;
   logic              vblank_s;
   logic [31:0]       fifo_head_s;
   sprite_cmd_t       head_s;
   logic              fifo_full_s;
   logic              fifo_empty_s;
   logic [CNT_W-1:0]  fifo_count_s;

   assign vblank_s        = (vcount >= V_FIRST_BLANK) && (vcount <= V_LAST_BLANK);
   assign push_s          = avs_write && avs_chipselect && !fifo_full_s;
   assign head_s          = sprite_cmd_t'(fifo_head_s);
   assign avs_waitrequest = (fifo_count_s == CNT_W'(FIFO_DEPTH));
   assign writedata       = writedata_r;
   assign front_buffer    = front_r;

   cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_s),
      .push_data (avs_writedata),
      .pop       (pop_s),
      .head      (fifo_head_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s),
      .count     (fifo_count_s)
   );

   // Next-state, pop and broadcast-word selection.
   always_comb begin
      state_nxt_s = state_r;
      wd_nxt_s    = 32'h0000_0000;
      pop_s       = 1'b0;
      swap_s      = 1'b0;
      case (state_r)
         ST_DRAIN: begin
            if (fifo_empty_s) begin
               wd_nxt_s = 32'h0000_0000;
            end else if (head_s.action == ACTION_SWAP) begin
               pop_s       = 1'b1;
               state_nxt_s = ST_WAIT_VB;
            end else begin
               pop_s    = 1'b1;
               wd_nxt_s = to_back_buffer(head_s, ~front_r);
            end
         end
         ST_WAIT_VB: begin
            // Queue stays frozen so post-commit writes cannot hit the old back buffer.
            if (vblank_s && swap_armed_r) begin
               swap_s      = 1'b1;
               wd_nxt_s    = make_swap_cmd(~front_r);
               state_nxt_s = ST_DRAIN;
            end else begin
               state_nxt_s = ST_WAIT_VB;
            end
         end
         default: begin
            state_nxt_s = ST_DRAIN;
         end
      endcase
   end

   // State, broadcast register, displayed buffer and once-per-frame swap arming.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= ST_DRAIN;
         writedata_r  <= 32'h0000_0000;
         front_r      <= 1'b0;
         swap_armed_r <= 1'b1;
      end else begin
         state_r     <= state_nxt_s;
         writedata_r <= wd_nxt_s;
         front_r     <= swap_s ? ~front_r : front_r;
         if (!vblank_s) begin
            swap_armed_r <= 1'b1;
         end else if (swap_s) begin
            swap_armed_r <= 1'b0;
         end else begin
            swap_armed_r <= swap_armed_r;
         end
      end
   end

`ifdef SEQ_STATUS_EN
   logic [15:0] swap_count_r;
   logic [31:0] readdata_r;

   assign avs_readdata = readdata_r;

   // Frame swap counter and registered status readback.
   always_ff @(posedge clk) begin
      if (reset) begin
         swap_count_r <= 16'h0000;
         readdata_r   <= 32'h0000_0000;
      end else begin
         swap_count_r <= swap_s ? swap_count_r + 16'd1 : swap_count_r;
         if (avs_read && avs_chipselect) begin
            readdata_r <= {swap_count_r, 7'b000_0000, front_r,
                           (state_r == ST_WAIT_VB), 7'(fifo_count_s)};
         end else begin
            readdata_r <= readdata_r;
         end
      end
   end
`endif

endmodule

// File: tb/tb_sprite_cmd_sequencer.sv
// Directed self-checking bench for sprite_cmd_sequencer.
module tb_sprite_cmd_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        avs_write;
   logic        avs_chipselect;
   logic [31:0] avs_writedata;
   logic        avs_waitrequest;
   logic [9:0]  vcount;
   logic [31:0] writedata;
   logic        front_buffer;
`ifdef SEQ_STATUS_EN
   logic        avs_read;
   logic [31:0] avs_readdata;
`endif

   int checks = 0;
   int errors = 0;

   localparam logic [31:0] COMMIT = 32'h001E_0000;

   always #5 clk = ~clk;

   sprite_cmd_sequencer dut (
      .clk             (clk),
      .reset           (reset),
      .avs_write       (avs_write),
      .avs_chipselect  (avs_chipselect),
      .avs_writedata   (avs_writedata),
      .avs_waitrequest (avs_waitrequest),
      .vcount          (vcount),
      .writedata       (writedata),
      .front_buffer    (front_buffer)
`ifdef SEQ_STATUS_EN
      ,
      .avs_read        (avs_read),
      .avs_readdata    (avs_readdata)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $display("FAIL %s: observed=%h expected=%h", tag, got, exp);
         $error("check %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   initial begin
      reset          = 1'b1;
      avs_write      = 1'b0;
      avs_chipselect = 1'b1;
      avs_writedata  = 32'h0000_0000;
      vcount         = 10'd100;
`ifdef SEQ_STATUS_EN
      avs_read       = 1'b0;
`endif
      tick();
      tick();
      reset = 1'b0;
      check("rst_writedata", writedata, 32'h0);
      check("rst_front", {31'd0, front_buffer}, 32'h0);
      check("rst_waitreq", {31'd0, avs_waitrequest}, 32'h0);

      // Single sprite write: bit13 forced to back buffer (1), two-cycle latency
      avs_writedata = 32'h2802_4005;
      avs_write     = 1'b1;
      tick();
      avs_write = 1'b0;
      check("latency_1cyc", writedata, 32'h0);
      tick();
      check("write_back", writedata, 32'h2802_6005);
      tick();
      check("nop_after_write", writedata, 32'h0);

      // Commit then 17 writes while stalled in WAIT_VB at vcount 100
      avs_writedata = COMMIT;
      avs_write     = 1'b1;
      tick();
      for (int i = 0; i < 17; i++) begin
         avs_writedata = 32'h0C02_A000 | 32'(i);
         tick();
         if (i == 14) check("not_full_15", {31'd0, avs_waitrequest}, 32'h0);
         if (i == 15) check("full_16", {31'd0, avs_waitrequest}, 32'd1);
      end
      avs_write = 1'b0;
      check("full_hold", {31'd0, avs_waitrequest}, 32'd1);
      repeat (3) tick();
      check("wait_vb_nop", writedata, 32'h0);
      check("wait_vb_front", {31'd0, front_buffer}, 32'h0);
      vcount = 10'd479;
      tick();
      check("line479_nop", writedata, 32'h0);
      vcount = 10'd480;
      tick();
      check("swap1_word", writedata, 32'h001E_2000);
      check("swap1_front", {31'd0, front_buffer}, 32'd1);
      for (int i = 0; i < 16; i++) begin
         tick();
         check("drain", writedata, 32'h0C02_8000 | 32'(i));
         if (i == 0) check("drain_waitreq", {31'd0, avs_waitrequest}, 32'h0);
      end
      tick();
      check("drain_end_17th_dropped", writedata, 32'h0);

      // Two commits inside one vblank: second waits for the next frame
      vcount = 10'd100;
      tick();
      vcount        = 10'd490;
      avs_writedata = COMMIT;
      avs_write     = 1'b1;
      tick();
      tick();
      avs_write = 1'b0;
      check("c1_enter_wait", writedata, 32'h0);
      tick();
      check("swap2_word", writedata, 32'h001E_0000);
      check("swap2_front", {31'd0, front_buffer}, 32'h0);
      repeat (4) tick();
      check("second_held", writedata, 32'h0);
      check("second_held_front", {31'd0, front_buffer}, 32'h0);
      vcount = 10'd0;
      tick();
      check("line0_nop", writedata, 32'h0);
      vcount = 10'd480;
      tick();
      check("swap3_word", writedata, 32'h001E_2000);
      check("swap3_front", {31'd0, front_buffer}, 32'd1);

      // Reset while in WAIT_VB with 5 entries queued
      vcount        = 10'd100;
      avs_writedata = COMMIT;
      avs_write     = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         avs_writedata = 32'h0C02_A010 | 32'(i);
         tick();
      end
      avs_write = 1'b0;
      check("pre_reset_front", {31'd0, front_buffer}, 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midrst_writedata", writedata, 32'h0);
      check("midrst_front", {31'd0, front_buffer}, 32'h0);
      check("midrst_waitreq", {31'd0, avs_waitrequest}, 32'h0);
      repeat (3) tick();
      check("midrst_flushed", writedata, 32'h0);

      // Commit on the excluded last blank line (524): swap only at next 480
      vcount        = 10'd524;
      avs_writedata = COMMIT;
      avs_write     = 1'b1;
      tick();
      avs_write = 1'b0;
      repeat (3) tick();
      check("line524_nop", writedata, 32'h0);
      check("line524_front", {31'd0, front_buffer}, 32'h0);
      vcount = 10'd0;
      tick();
      check("next_frame_line0", writedata, 32'h0);
      vcount = 10'd479;
      tick();
      check("next_frame_line479", writedata, 32'h0);
      vcount = 10'd480;
      tick();
      check("swap4_word", writedata, 32'h001E_2000);
      check("swap4_front", {31'd0, front_buffer}, 32'd1);

      // With front = 1 the back buffer is 0; host bit13 = 1 is overridden
      avs_writedata = 32'h2802_6005;
      avs_write     = 1'b1;
      tick();
      avs_write = 1'b0;
      tick();
      check("write_back0", writedata, 32'h2802_4005);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
